ntt_issue_ctrl: RTL and testbench
=================================

// Module: ntt_issue_ctrl
// PURPOSE
//  Downstream of the instruction decoder. Consumes the decoded accelerator-class op
//  (size==7: NTT / INVNTT / PWAM / LPWAM) and launches the polynomial accelerator.
//  Stalls the pipeline until the accelerator finishes, then releases it with a one-cycle done pulse.
//  Flags an error for misaligned base addresses and for timeouts.
// PARAMETERS
//  ADDR_W        32    accelerator base-address width; equals the low bits of rs1
//  TIMEOUT_CYC   4096  WAIT cycles before timeout; must be >= 2
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  dec_valid  in   1       decoded instruction valid in the decode/execute slot
//  dec_size   in   3       decoder size field; 3'd7 marks an accelerator op
//  dec_funct7 in   7       selects the op: 0000011 NTT, 0000100 INVNTT, 0000111 PWAM, 0000101 LPWAM
//  dec_ntt_md in   1       decoder NTT direction (1 = forward); used for NTT/INVNTT only
//  rs1_val    in   64      base address operand
//  flush      in   1       pipeline flush
//  acc_busy   in   1       accelerator not ready to accept a start
//  acc_done   in   1       accelerator completion pulse
//  acc_start  out  1       one-cycle launch strobe
//  acc_mode   out  2       0 NTT, 1 INVNTT, 2 PWAM, 3 LPWAM; held stable from ISSUE to DONE
//  acc_addr   out  ADDR_W  base address; held stable from ISSUE to DONE
//  stall      out  1       freeze the upstream pipeline
//  op_done    out  1       one-cycle pulse when the op retires
//  err        out  1       sticky error flag
//  err_clr    in   1       clears err
// BEHAVIOUR
//  Reset values: state=IDLE; acc_start=0; acc_mode=0; acc_addr=0; stall=0; op_done=0; err=0; counter=0.
//  is_acc = dec_valid & (dec_size==3'd7) & known funct7 & ~flush.
//  Unknown funct7 with size==7 is treated as a NOP: no stall, no err.
//  States and transitions:
//   IDLE:  on is_acc, capture mode and rs1_val[ADDR_W-1:0].
//          If rs1_val[2:0] != 0: set err and go to DONE; no launch.
//          Otherwise go to ISSUE. Not accelerator-class: stay in IDLE.
//   ISSUE: if acc_busy, stay here with acc_start=0.
//          Else acc_start=1 for exactly this cycle, clear the counter, go to WAIT.
//   WAIT:  acc_done is sampled only in this state.
//          On acc_done, go to DONE.
//          When the counter reaches TIMEOUT_CYC-1 without acc_done: set err, go to DONE.
//          Otherwise the counter increments.
//   DONE:  op_done=1 for one cycle, stall=0, go to IDLE.
//  stall is combinational: (state==IDLE & is_acc) | state==ISSUE | state==WAIT.
//  The decoded instruction is therefore held from its first cycle.
//  Latency with acc_busy=0 and acc_done N cycles after acc_start: op_done N+2 cycles after
//  the is_acc cycle. stall is high for N+2 cycles.
//  acc_done outside WAIT (stray or late) is ignored. acc_done on the timeout cycle wins: no err.
//  flush in IDLE suppresses capture. In ISSUE, WAIT or DONE flush is ignored; a launched op always completes.
//  err_clr and an err-set event in the same cycle: set wins.
//  Reset mid-operation returns to IDLE immediately and drops stall and acc_start.
//  The accelerator shares rst, so no cleanup handshake is needed.
//  A back-to-back accelerator op may be accepted in the cycle after DONE; there is no same-cycle re-issue.
//  Counter width is $clog2(TIMEOUT_CYC).
// STRUCTURE
//  common.vh holds the shared constants:
//   ACC_SIZE (3'd7)
//   FUNCT7_NTT / _INVNTT / _PWAM / _LPWAM
//   ACC_MODE_* encodings
//   state encodings
//  Sub-module acc_timeout_ctr (clear, enable, expired output; parameterised by TIMEOUT_CYC).
//  The FSM and the capture registers stay in ntt_issue_ctrl.
// TESTING
//  1. NTT, rs1=0x1000, acc_busy=0, acc_done 5 cycles after start
//     -> acc_mode=0, acc_addr=0x1000, single acc_start pulse, stall high 7 cycles, op_done pulse, err=0.
//  2. PWAM, acc_busy high 3 cycles -> stays in ISSUE, acc_start only in the first busy-free cycle, mode=2.
//  3. LPWAM, rs1=0x1004 (misaligned) -> no acc_start, err=1, op_done 1 cycle later, stall high 1 cycle.
//  4. TIMEOUT_CYC=16, acc_done never arrives -> err=1 after 16 WAIT cycles, op_done pulse;
//     err_clr then clears err.
//  5. INVNTT with flush in the same cycle -> no stall, no start. flush during WAIT -> op still completes normally.
//  6. rst asserted in WAIT -> stall and acc_start drop asynchronously. Stray acc_done in IDLE afterwards -> no op_done.

Source files
------------

// File: rtl/ntt_issue_ctrl_pkg.sv
// Shared constants, state type and funct7 decode for the polynomial-accelerator issue controller.
package ntt_issue_ctrl_pkg;

    localparam logic [2:0] ACC_SIZE      = 3'd7;

    localparam logic [6:0] FUNCT7_NTT    = 7'b0000011;
    localparam logic [6:0] FUNCT7_INVNTT = 7'b0000100;
    localparam logic [6:0] FUNCT7_PWAM   = 7'b0000111;
    localparam logic [6:0] FUNCT7_LPWAM  = 7'b0000101;

    localparam logic [1:0] ACC_MODE_NTT    = 2'd0;
    localparam logic [1:0] ACC_MODE_INVNTT = 2'd1;
    localparam logic [1:0] ACC_MODE_PWAM   = 2'd2;
    localparam logic [1:0] ACC_MODE_LPWAM  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic       known;
        logic [1:0] mode;
    } op_dec_t;

    function automatic op_dec_t decode_funct7(input logic [6:0] f7);
        op_dec_t d;
        d.known = 1'b1;
        d.mode  = ACC_MODE_NTT;
        case (f7)
            FUNCT7_NTT:    d.mode = ACC_MODE_NTT;
            FUNCT7_INVNTT: d.mode = ACC_MODE_INVNTT;
            FUNCT7_PWAM:   d.mode = ACC_MODE_PWAM;
            FUNCT7_LPWAM:  d.mode = ACC_MODE_LPWAM;
            default:       d.known = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ntt_issue_ctrl_acc_timeout_ctr.sv
// WAIT-state cycle counter; expired is high while the count sits at TIMEOUT_CYC-1.
module acc_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt_q;

    assign expired = (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Saturate at the terminal count so a stalled FSM can never see a wrapped value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ntt_issue_ctrl.sv
// Issue controller: launches the polynomial accelerator for size==7 ops, stalls the pipeline
// until completion, retires with a one-cycle op_done and raises a sticky err on misalignment/timeout.
module ntt_issue_ctrl
    import ntt_issue_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [2:0]        dec_size,
    input  logic [6:0]        dec_funct7,
    input  logic              dec_ntt_md,
    input  logic [63:0]       rs1_val,
    input  logic              flush,
    input  logic              acc_busy,
    input  logic              acc_done,
    output logic              acc_start,
    output logic [1:0]        acc_mode,
    output logic [ADDR_W-1:0] acc_addr,
    output logic              stall,
    output logic              op_done,
    output logic              err,
    input  logic              err_clr
);

    state_e              state_q;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                err_q;

    op_dec_t             op_dec;
    logic                is_acc;
    logic                misaligned;
    logic                issue_fire;
    logic                timeout_hit;
    logic                err_set;

    // Direction is already implied by funct7; the upper rs1 bits are beyond the address space.
    logic                unused_inputs;
    assign unused_inputs = ^{dec_ntt_md, rs1_val};

    assign op_dec     = decode_funct7(dec_funct7);
    assign is_acc     = dec_valid && (dec_size == ACC_SIZE) && op_dec.known && !flush;
    assign misaligned = (rs1_val[2:0] != 3'b000);
    assign issue_fire = (state_q == ST_ISSUE) && !acc_busy;

    assign err_set = ((state_q == ST_IDLE) && is_acc && misaligned)
                   || ((state_q == ST_WAIT) && !acc_done && timeout_hit);

    acc_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (issue_fire),
        .enable  (state_q == ST_WAIT),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= ACC_MODE_NTT;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_acc) begin
                        mode_q  <= op_dec.mode;
                        addr_q  <= rs1_val[ADDR_W-1:0];
                        state_q <= misaligned ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!acc_busy) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (acc_done || timeout_hit) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // Strobes decode straight from the reset-cleared state register so reset drops them at once.
    assign acc_start = issue_fire;
    assign op_done   = (state_q == ST_DONE);
    assign stall     = ((state_q == ST_IDLE) && is_acc)
                     || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign acc_mode  = mode_q;
    assign acc_addr  = addr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ntt_issue_ctrl.sv
// Directed bench for ntt_issue_ctrl with a scoreboard of expected mode/address/err per op.
module tb_ntt_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [2:0]  dec_size;
    logic [6:0]  dec_funct7;
    logic        dec_ntt_md;
    logic [63:0] rs1_val;
    logic        flush;
    logic        acc_busy;
    logic        acc_done;
    logic        acc_start;
    logic [1:0]  acc_mode;
    logic [31:0] acc_addr;
    logic        stall;
    logic        op_done;
    logic        err;
    logic        err_clr;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ntt_issue_ctrl #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dec_valid  (dec_valid),
        .dec_size   (dec_size),
        .dec_funct7 (dec_funct7),
        .dec_ntt_md (dec_ntt_md),
        .rs1_val    (rs1_val),
        .flush      (flush),
        .acc_busy   (acc_busy),
        .acc_done   (acc_done),
        .acc_start  (acc_start),
        .acc_mode   (acc_mode),
        .acc_addr   (acc_addr),
        .stall      (stall),
        .op_done    (op_done),
        .err        (err),
        .err_clr    (err_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] m, input logic [31:0] a, input logic e);
        exp_t x;
        x.mode = m;
        x.addr = a;
        x.err  = e;
        sb.push_back(x);
    endtask

    // Cycle 0 is the is_acc cycle. acc_busy is held high during cycles 1..busy_cyc,
    // acc_done pulses done_dly cycles after acc_start (0 = never), optional flush mid-WAIT.
    task automatic run_op(input string name, input logic [6:0] f7, input logic md,
                          input logic [63:0] rs1, input int busy_cyc, input int done_dly,
                          input bit flush_wait,
                          output int n_stall, output int n_start, output int start_cyc,
                          output int done_cyc, output int n_opdone);
        exp_t x;
        n_stall = 0; n_start = 0; n_opdone = 0; start_cyc = -1; done_cyc = -1;
        dec_valid = 1'b1; dec_size = 3'd7; dec_funct7 = f7; dec_ntt_md = md; rs1_val = rs1;
        acc_busy = 1'b0; acc_done = 1'b0; flush = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (acc_start) begin
                n_start++;
                if (start_cyc < 0) start_cyc = c;
                check({name, "_sb_at_start"}, sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check({name, "_mode_at_start"}, acc_mode, sb[0].mode);
                    check({name, "_addr_at_start"}, acc_addr, sb[0].addr);
                end
            end
            if (op_done) begin
                n_opdone++;
                done_cyc = c;
                check({name, "_sb_at_done"}, sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    x = sb.pop_front();
                    check({name, "_mode_at_done"}, acc_mode, x.mode);
                    check({name, "_addr_at_done"}, acc_addr, x.addr);
                    check({name, "_err_at_done"}, err, x.err);
                end
            end
            @(posedge clk);
            #1;
            dec_valid = 1'b0;
            acc_busy  = (c + 1 >= 1) && (c + 1 <= busy_cyc);
            acc_done  = (start_cyc >= 0) && (done_dly > 0) && (c + 1 == start_cyc + done_dly);
            flush     = flush_wait && (start_cyc >= 0) && (c + 1 == start_cyc + 2);
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        acc_busy = 1'b0; acc_done = 1'b0; flush = 1'b0;
        check({name, "_op_done_seen"}, done_cyc >= 0, 1);
    endtask

    int n_stall, n_start, start_cyc, done_cyc, n_opdone;
    logic seen;

    initial begin
        rst = 1'b1;
        dec_valid = 1'b0; dec_size = 3'd0; dec_funct7 = 7'd0; dec_ntt_md = 1'b0;
        rs1_val = '0; flush = 1'b0; acc_busy = 1'b0; acc_done = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_acc_start", acc_start, 0);
        check("rst_acc_mode", acc_mode, 0);
        check("rst_acc_addr", acc_addr, 0);
        check("rst_stall", stall, 0);
        check("rst_op_done", op_done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1. NTT, acc_done 5 cycles after start
        push_exp(2'd0, 32'h0000_1000, 1'b0);
        run_op("t1", 7'b0000011, 1'b1, 64'h1000, 0, 5, 1'b0,
               n_stall, n_start, start_cyc, done_cyc, n_opdone);
        check("t1_n_start", n_start, 1);
        check("t1_start_cyc", start_cyc, 1);
        check("t1_stall_cycles", n_stall, 7);
        check("t1_done_cyc", done_cyc, 7);
        check("t1_n_opdone", n_opdone, 1);

        // 2. PWAM with acc_busy through three ISSUE cycles
        push_exp(2'd2, 32'h0000_2000, 1'b0);
        run_op("t2", 7'b0000111, 1'b0, 64'h2000, 3, 2, 1'b0,
               n_stall, n_start, start_cyc, done_cyc, n_opdone);
        check("t2_n_start", n_start, 1);
        check("t2_start_cyc", start_cyc, 4);
        check("t2_done_cyc", done_cyc, 7);
        check("t2_stall_cycles", n_stall, 7);

        // 3. LPWAM misaligned
        push_exp(2'd3, 32'h0000_1004, 1'b1);
        run_op("t3", 7'b0000101, 1'b0, 64'h1004, 0, 0, 1'b0,
               n_stall, n_start, start_cyc, done_cyc, n_opdone);
        check("t3_n_start", n_start, 0);
        check("t3_done_cyc", done_cyc, 1);
        check("t3_stall_cycles", n_stall, 1);
        check("t3_err_sticky", err, 1);

        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("t3_err_clr", err, 0);

        // 4. Timeout with err_clr held high: set beats clear, then clear takes effect
        err_clr = 1'b1;
        push_exp(2'd0, 32'h0000_3000, 1'b1);
        run_op("t4", 7'b0000011, 1'b1, 64'h3000, 0, 0, 1'b0,
               n_stall, n_start, start_cyc, done_cyc, n_opdone);
        check("t4_done_cyc", done_cyc, 18);
        check("t4_stall_cycles", n_stall, 18);
        check("t4_err_cleared_after", err, 0);
        err_clr = 1'b0;

        // 4b. acc_done on the terminal count wins over timeout
        push_exp(2'd0, 32'h0000_3008, 1'b0);
        run_op("t4b", 7'b0000011, 1'b1, 64'h3008, 0, 16, 1'b0,
               n_stall, n_start, start_cyc, done_cyc, n_opdone);
        check("t4b_done_cyc", done_cyc, 18);
        check("t4b_err", err, 0);

        // 5a. INVNTT with flush in the same cycle
        dec_valid = 1'b1; dec_size = 3'd7; dec_funct7 = 7'b0000100; rs1_val = 64'h4000; flush = 1'b1;
        @(negedge clk);
        check("t5_flush_stall", stall, 0);
        @(posedge clk); #1;
        dec_valid = 1'b0; flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | acc_start | op_done | stall;
            @(posedge clk); #1;
        end
        check("t5_flush_no_activity", seen, 0);

        // 5b. flush during WAIT is ignored
        push_exp(2'd1, 32'h0000_4000, 1'b0);
        run_op("t5b", 7'b0000100, 1'b0, 64'h4000, 0, 4, 1'b1,
               n_stall, n_start, start_cyc, done_cyc, n_opdone);
        check("t5b_n_start", n_start, 1);
        check("t5b_done_cyc", done_cyc, 6);

        // Unknown funct7 with size 7 is a NOP
        dec_valid = 1'b1; dec_size = 3'd7; dec_funct7 = 7'b0000001; rs1_val = 64'h5003;
        @(negedge clk);
        check("nop_stall", stall, 0);
        @(posedge clk); #1;
        dec_valid = 1'b0;
        @(negedge clk);
        check("nop_no_start", acc_start, 0);
        check("nop_err", err, 0);
        @(posedge clk); #1;

        // 6a. reset while acc_start is high
        dec_valid = 1'b1; dec_size = 3'd7; dec_funct7 = 7'b0000011; rs1_val = 64'h6000;
        @(posedge clk); #1;
        dec_valid = 1'b0;
        @(negedge clk);
        check("t6_start_before_rst", acc_start, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_start_async_drop", acc_start, 0);
        check("t6_stall_async_drop_issue", stall, 0);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // 6b. reset in WAIT, then a stray acc_done in IDLE
        dec_valid = 1'b1; dec_size = 3'd7; dec_funct7 = 7'b0000111; rs1_val = 64'h7000;
        repeat (3) @(posedge clk);
        #1 dec_valid = 1'b0;
        @(negedge clk);
        check("t6_stall_in_wait", stall, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_stall_async_drop_wait", stall, 0);
        check("t6_addr_reset", acc_addr, 0);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        acc_done = 1'b1;
        @(posedge clk); #1;
        acc_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | op_done | stall;
            @(posedge clk); #1;
        end
        check("t6_stray_done_ignored", seen, 0);

        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
